// File: rtl/serial_logic_unit_pkg.sv
// Shared definitions for the bit-serial logic unit: opcodes, FSM states and
// the slice-counter width helper.
package serial_logic_unit_pkg;

    localparam logic [2:0] OP_INV  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Slice counter must index NSLICE slices but is never narrower than 1 bit.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/serial_logic_unit_slice.sv
// Single-bit gate primitives and the combinational SLICE-bit logic slice
// built from them; one slice is evaluated per RUN cycle.
module sl_inv (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module sl_and2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module sl_nand2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module sl_or2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module sl_xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module logic_slice
    import serial_logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_slice_i,
    input  logic [SLICE-1:0] b_slice_i,
    input  logic [2:0]       op_i,
    output logic [SLICE-1:0] y_slice_o,
    output logic             err_o
);

    logic [SLICE-1:0] inv_a;
    logic [SLICE-1:0] and_ab;
    logic [SLICE-1:0] nand_ab;
    logic [SLICE-1:0] or_ab;
    logic [SLICE-1:0] xor_ab;
    logic [SLICE-1:0] nor_ab;
    logic [SLICE-1:0] xnor_ab;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        sl_inv   u_inv   (.a_i(a_slice_i[i]),                      .y_o(inv_a[i]));
        sl_and2  u_and2  (.a_i(a_slice_i[i]), .b_i(b_slice_i[i]), .y_o(and_ab[i]));
        sl_nand2 u_nand2 (.a_i(a_slice_i[i]), .b_i(b_slice_i[i]), .y_o(nand_ab[i]));
        sl_or2   u_or2   (.a_i(a_slice_i[i]), .b_i(b_slice_i[i]), .y_o(or_ab[i]));
        sl_xor2  u_xor2  (.a_i(a_slice_i[i]), .b_i(b_slice_i[i]), .y_o(xor_ab[i]));
        // NOR and XNOR reuse the OR/XOR gates followed by an inverter.
        sl_inv   u_nor   (.a_i(or_ab[i]),                          .y_o(nor_ab[i]));
        sl_inv   u_xnor  (.a_i(xor_ab[i]),                         .y_o(xnor_ab[i]));
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        y_slice_o = '0;
        err_o     = 1'b0;
        case (op_i)
            OP_INV:  y_slice_o = inv_a;
            OP_AND:  y_slice_o = and_ab;
            OP_NAND: y_slice_o = nand_ab;
            OP_OR:   y_slice_o = or_ab;
            OP_XOR:  y_slice_o = xor_ab;
            OP_NOR:  y_slice_o = nor_ab;
            OP_XNOR: y_slice_o = xnor_ab;
            default: err_o     = 1'b1;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: accepts two operands and an opcode, evaluates
// SLICE bits per cycle, then holds the result and flags until consumed.
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             err
);

    localparam int             NSLICE   = WIDTH / SLICE;
    localparam int             CNT_W    = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic               zero_q;
    logic               parity_q;
    logic               err_q;
    logic               out_valid_q;

    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [SLICE-1:0]   y_slice;
    logic               slice_err;
    logic               accept;

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    assign a_slice = a_q[int'(cnt_q)*SLICE +: SLICE];
    assign b_slice = b_q[int'(cnt_q)*SLICE +: SLICE];

    logic_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a_slice_i (a_slice),
        .b_slice_i (b_slice),
        .op_i      (op_q),
        .y_slice_o (y_slice),
        .err_o     (slice_err)
    );

    // Result word with the current slice merged in; flags are taken from this
    // value on the last slice so they reflect the complete result.
    always_comb begin
        result_d = result_q;
        result_d[int'(cnt_q)*SLICE +: SLICE] = y_slice;
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        result_q <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        zero_q      <= (result_d == '0);
                        parity_q    <= ^result_d;
                        err_q       <= slice_err;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit: default 16/4 instance plus the
// NSLICE=1 and NSLICE=8 parameter corners.
module tb_serial_logic_unit;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        p;
        logic        e;
    } exp_t;

    logic clk;
    logic reset;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        parity;
    logic        err;

    logic        sw_valid;
    logic [7:0]  sw_a;
    logic [7:0]  sw_b;
    logic [2:0]  sw_op;
    logic        sw_out_ready;
    logic        n1_in_ready, n1_out_valid, n1_zero, n1_parity, n1_err;
    logic [7:0]  n1_result;
    logic        n8_in_ready, n8_out_valid, n8_zero, n8_parity, n8_err;
    logic [7:0]  n8_result;

    int total = 0;
    int bad   = 0;
    exp_t       exp_q[$];
    logic [7:0] sw_q[$];

    serial_logic_unit #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity), .err(err)
    );

    serial_logic_unit #(.WIDTH(8), .SLICE(8)) u_n1 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(n1_in_ready),
        .a(sw_a), .b(sw_b), .op(sw_op), .out_valid(n1_out_valid), .out_ready(sw_out_ready),
        .result(n1_result), .zero(n1_zero), .parity(n1_parity), .err(n1_err)
    );

    serial_logic_unit #(.WIDTH(8), .SLICE(1)) u_n8 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(n8_in_ready),
        .a(sw_a), .b(sw_b), .op(sw_op), .out_valid(n8_out_valid), .out_ready(sw_out_ready),
        .result(n8_result), .zero(n8_zero), .parity(n8_parity), .err(n8_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] r, input logic z, input logic p, input logic e);
        exp_t x;
        x.res = r; x.z = z; x.p = p; x.e = e;
        return x;
    endfunction

    function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            3'b000:  return ~x;
            3'b001:  return x & y;
            3'b010:  return ~(x & y);
            3'b011:  return x | y;
            3'b100:  return x ^ y;
            3'b101:  return ~(x | y);
            3'b110:  return ~(x ^ y);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1; op = o; a = aa; b = bb;
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge; waits for out_valid and pops the scoreboard.
    task automatic collect(input string tag, input int exp_lat);
        int   n = 0;
        exp_t e;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got=%0d want=%0d", tag, n, exp_lat);
        end
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (result !== e.res) begin bad++; $display("FAIL %s result: got=%h want=%h", tag, result, e.res); end
        total++;
        if (zero !== e.z) begin bad++; $display("FAIL %s zero: got=%b want=%b", tag, zero, e.z); end
        total++;
        if (parity !== e.p) begin bad++; $display("FAIL %s parity: got=%b want=%b", tag, parity, e.p); end
        total++;
        if (err !== e.e) begin bad++; $display("FAIL %s err: got=%b want=%b", tag, err, e.e); end
        if (out_ready === 1'b1) begin
            tick();
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s post_handshake: in_ready=%b out_valid=%b want 1/0", tag, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got=%b want 0", in_ready); end
        total++;
        if ({out_valid, result, zero, parity, err} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: ov=%b res=%h z=%b p=%b e=%b want all 0", out_valid, result, zero, parity, err);
        end
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got=%b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        exp_q.push_back(mk(16'h0FF0, 1'b0, 1'b0, 1'b0));
        issue(3'b100, 16'hF0F0, 16'hFF00);
        collect("xor", 4);
        exp_q.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0));
        issue(3'b010, 16'hFFFF, 16'hFFFF);
        collect("nand", 4);
        exp_q.push_back(mk(16'hFFFE, 1'b0, 1'b1, 1'b0));
        issue(3'b101, 16'h0000, 16'h0001);
        collect("nor", 4);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q.push_back(mk(16'h1235, 1'b0, 1'b0, 1'b0));
        issue(3'b011, 16'h1234, 16'h0001);
        collect("or_stall", 4);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (result !== 16'h1235 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: res=%h ov=%b ir=%b want 1235/1/0", i, result, out_valid, in_ready);
            end
            if (i == 2) begin in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 3'b001; end
            if (i == 7) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        issue(3'b001, 16'hFFFF, 16'h00FF);
        tick();
        reset = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midrun_ready_in_reset: got=%b want 0", in_ready); end
        tick();
        total++;
        if ({out_valid, result, zero, parity, err} !== 20'h0) begin
            bad++;
            $display("FAIL midrun_cleared: ov=%b res=%h z=%b p=%b e=%b want all 0", out_valid, result, zero, parity, err);
        end
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrun_release_ready: got=%b want 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_no_output[%0d]: ov=%b want 0", i, out_valid); end
            tick();
        end
        exp_q.push_back(mk(16'hFF00, 1'b0, 1'b0, 1'b0));
        issue(3'b000, 16'h00FF, 16'h0000);
        collect("inv_after_reset", 4);
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        exp_q.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b1));
        issue(3'b111, 16'hAAAA, 16'h5555);
        collect("reserved", 4);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 16'($urandom);
            y = 16'($urandom);
            r = model(o, x, y);
            exp_q.push_back(mk(r, (r == 16'h0), ^r, (o == 3'b111)));
            issue(o, x, y);
            collect("b2b", 4);
        end
    endtask

    task automatic test_param_sweep();
        int n1 = -1;
        int n8 = -1;
        logic [7:0] e;
        sw_out_ready = 1'b1;
        total++;
        if (n1_in_ready !== 1'b1 || n8_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL sweep_ready: n1=%b n8=%b want 1/1", n1_in_ready, n8_in_ready);
        end
        sw_q.push_back(8'h33);
        sw_q.push_back(8'h33);
        sw_valid = 1'b1; sw_a = 8'hC3; sw_b = 8'h0F; sw_op = 3'b110;
        tick();
        sw_valid = 1'b0;
        for (int c = 0; c < 20 && (n1 < 0 || n8 < 0); c++) begin
            if (n1 < 0 && n1_out_valid === 1'b1) begin
                n1 = c;
                e = sw_q.pop_front();
                total++;
                if ({n1_result, n1_zero, n1_parity, n1_err} !== {e, 3'b000}) begin
                    bad++;
                    $display("FAIL sweep_n1_value: res=%h z=%b p=%b e=%b want %h/0/0/0", n1_result, n1_zero, n1_parity, n1_err, e);
                end
            end
            if (n8 < 0 && n8_out_valid === 1'b1) begin
                n8 = c;
                e = sw_q.pop_front();
                total++;
                if ({n8_result, n8_zero, n8_parity, n8_err} !== {e, 3'b000}) begin
                    bad++;
                    $display("FAIL sweep_n8_value: res=%h z=%b p=%b e=%b want %h/0/0/0", n8_result, n8_zero, n8_parity, n8_err, e);
                end
            end
            if (n1 < 0 || n8 < 0) tick();
        end
        total++;
        if (n1 != 1) begin bad++; $display("FAIL sweep_n1_latency: got=%0d want=1", n1); end
        total++;
        if (n8 != 8) begin bad++; $display("FAIL sweep_n8_latency: got=%0d want=8", n8); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_op = '0; sw_out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_reserved();
        test_back_to_back();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
